// File: rtl/uart_cmd_pkg.sv
// Shared types and constants for the UART byte-to-command assembler.
// Timing defaults assume a 50 MHz clock and 2604 clocks per baud.
package uart_cmd_pkg;

    typedef enum logic {
        IDLE,
        COLLECT
    } asm_state_t;

    localparam int BAUD_CLKS        = 2604;
    localparam int DEF_CMD_BYTES    = 3;
    localparam int DEF_TIMEOUT_CLKS = 65104;

endpackage

// File: rtl/cmd_timeout_tmr.sv
// Inter-byte watchdog timer. It counts while enabled and restarts on clear.
// It saturates at its last value, so it can never wrap into a false second expiry.
module cmd_timeout_tmr
    import uart_cmd_pkg::*;
#(
    parameter int TIMEOUT_CLKS = DEF_TIMEOUT_CLKS
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam int TW = (TIMEOUT_CLKS > 1) ? $clog2(TIMEOUT_CLKS) : 1;
    localparam logic [TW-1:0] LAST = TW'(TIMEOUT_CLKS - 1);

    logic [TW-1:0] count;

    // Held at zero whenever disabled, so each COLLECT period starts from a fresh count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear || !enable) begin
            count <= '0;
        end else if (count != LAST) begin
            count <= count + TW'(1);
        end
    end

    assign expire = enable && (count == LAST);

endmodule

// File: rtl/uart_cmd_assembler.sv
// Packs CMD_BYTES UART bytes, MSB first, into a command word with a held ready flag.
// An inter-byte timeout drops partial commands so framing recovers after a lost byte.
module uart_cmd_assembler
    import uart_cmd_pkg::*;
#(
    parameter int CMD_BYTES    = DEF_CMD_BYTES,
    parameter int TIMEOUT_CLKS = DEF_TIMEOUT_CLKS
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   rx_rdy,
    input  logic [7:0]             rx_data,
    output logic                   clr_rx_rdy,
    output logic [8*CMD_BYTES-1:0] cmd,
    output logic                   cmd_rdy,
    input  logic                   clr_cmd_rdy,
    output logic                   ovr,
    output logic                   tmo
);

    localparam int W  = 8 * CMD_BYTES;
    localparam int CW = $clog2(CMD_BYTES + 1);
    localparam logic [CW-1:0] LAST_BYTE = CW'(CMD_BYTES - 1);

    asm_state_t    state, next_state;
    logic [CW-1:0] byte_cnt, next_cnt;
    logic [W-1:0]  asm_reg;
    logic [W-1:0]  asm_shifted;
    logic          accept, complete, expire, timed_out, load, dropped;

    // Gated by rst_n so the strobe to the UART is also low while the block is held in reset.
    assign accept      = rx_rdy && rst_n;
    assign clr_rx_rdy  = accept;
    assign asm_shifted = (asm_reg << 8) | W'(rx_data);
    assign complete    = accept && (byte_cnt == LAST_BYTE);
    assign load        = complete && (!cmd_rdy || clr_cmd_rdy);
    assign dropped     = complete && cmd_rdy && !clr_cmd_rdy;

    cmd_timeout_tmr #(
        .TIMEOUT_CLKS(TIMEOUT_CLKS)
    ) u_tmr (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (accept),
        .enable(state == COLLECT),
        .expire(expire)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            byte_cnt <= '0;
        end else begin
            state    <= next_state;
            byte_cnt <= next_cnt;
        end
    end

    // An accept in the expiry cycle takes priority, so a late-but-legal byte is never dropped.
    always_comb begin
        next_state = state;
        next_cnt   = byte_cnt;
        timed_out  = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (complete) begin
                        next_cnt = '0;
                    end else begin
                        next_state = COLLECT;
                        next_cnt   = CW'(1);
                    end
                end
            end
            COLLECT: begin
                if (accept) begin
                    if (complete) begin
                        next_state = IDLE;
                        next_cnt   = '0;
                    end else begin
                        next_cnt = byte_cnt + CW'(1);
                    end
                end else if (expire) begin
                    next_state = IDLE;
                    next_cnt   = '0;
                    timed_out  = 1'b1;
                end
            end
            default: begin
                next_state = IDLE;
                next_cnt   = '0;
            end
        endcase
    end

    // cmd is a second buffer: collection continues while the consumer still owns the previous word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            asm_reg <= '0;
            cmd     <= '0;
            cmd_rdy <= 1'b0;
            ovr     <= 1'b0;
            tmo     <= 1'b0;
        end else begin
            if (accept) begin
                asm_reg <= asm_shifted;
            end
            if (load) begin
                cmd     <= asm_shifted;
                cmd_rdy <= 1'b1;
            end else if (clr_cmd_rdy) begin
                cmd_rdy <= 1'b0;
            end
            ovr <= dropped;
            tmo <= timed_out;
        end
    end

endmodule

// File: tb/tb_uart_cmd_assembler.sv
// Directed testbench for uart_cmd_assembler: table of full commands plus hand sequences
// for timeout, accept-versus-expiry and mid-command reset. A short timeout keeps runs brief.
module tb_uart_cmd_assembler;

    localparam int TMO = 40;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rx_rdy = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        clr_rx_rdy;
    logic [23:0] cmd;
    logic        cmd_rdy;
    logic        clr_cmd_rdy = 1'b0;
    logic        ovr;
    logic        tmo;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0]  b0, b1, b2;
        logic        ackAtEnd;
        logic        ackAfter;
        logic [23:0] expCmd;
        logic        expRdy;
        logic        expOvr;
    } vec_t;

    vec_t vecs[6];

    uart_cmd_assembler #(
        .CMD_BYTES   (3),
        .TIMEOUT_CLKS(TMO)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx_rdy     (rx_rdy),
        .rx_data    (rx_data),
        .clr_rx_rdy (clr_rx_rdy),
        .cmd        (cmd),
        .cmd_rdy    (cmd_rdy),
        .clr_cmd_rdy(clr_cmd_rdy),
        .ovr        (ovr),
        .tmo        (tmo)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Models the UART: rx_rdy held until the strobe is seen, then dropped the next cycle.
    task automatic sendByte(input logic [7:0] data, input logic ack, input string tag);
        rx_data     = data;
        rx_rdy      = 1'b1;
        clr_cmd_rdy = ack;
        #1;
        checkOutput({tag, " clr_rx_rdy high"}, 32'(clr_rx_rdy), 32'd1);
        @(posedge clk);
        #1;
        rx_rdy      = 1'b0;
        clr_cmd_rdy = 1'b0;
        #1;
        checkOutput({tag, " clr_rx_rdy low"}, 32'(clr_rx_rdy), 32'd0);
    endtask

    task automatic checkAll(input string tag, input logic [23:0] c, input logic r, input logic o, input logic t);
        checkOutput({tag, " cmd"}, 32'(cmd), 32'(c));
        checkOutput({tag, " cmd_rdy"}, 32'(cmd_rdy), 32'(r));
        checkOutput({tag, " ovr"}, 32'(ovr), 32'(o));
        checkOutput({tag, " tmo"}, 32'(tmo), 32'(t));
    endtask

    task automatic applyStimulus(input vec_t v, input string tag);
        sendByte(v.b0, 1'b0, tag);
        idle(2);
        sendByte(v.b1, 1'b0, tag);
        idle(2);
        sendByte(v.b2, v.ackAtEnd, tag);
        checkAll({tag, " done"}, v.expCmd, v.expRdy, v.expOvr, 1'b0);
        idle(1);
        checkOutput({tag, " ovr one cycle"}, 32'(ovr), 32'd0);
        if (v.ackAfter) begin
            clr_cmd_rdy = 1'b1;
            idle(1);
            clr_cmd_rdy = 1'b0;
            checkOutput({tag, " ack cmd_rdy"}, 32'(cmd_rdy), 32'd0);
            checkOutput({tag, " ack cmd held"}, 32'(cmd), 32'(v.expCmd));
        end
        idle(2);
    endtask

    initial begin
        int pulses;
        int firstAt;

        vecs[0] = '{8'hA5, 8'h3C, 8'h0F, 1'b0, 1'b1, 24'hA53C0F, 1'b1, 1'b0};
        vecs[1] = '{8'h01, 8'h02, 8'h03, 1'b0, 1'b0, 24'h010203, 1'b1, 1'b0};
        vecs[2] = '{8'h04, 8'h05, 8'h06, 1'b0, 1'b0, 24'h010203, 1'b1, 1'b1};
        vecs[3] = '{8'h04, 8'h05, 8'h06, 1'b1, 1'b1, 24'h040506, 1'b1, 1'b0};
        vecs[4] = '{8'hDE, 8'hAD, 8'hBE, 1'b1, 1'b0, 24'hDEADBE, 1'b1, 1'b0};
        vecs[5] = '{8'h12, 8'h34, 8'h56, 1'b0, 1'b1, 24'hDEADBE, 1'b1, 1'b1};

        #1;
        idle(2);
        checkAll("reset", 24'h0, 1'b0, 1'b0, 1'b0);
        checkOutput("reset clr_rx_rdy", 32'(clr_rx_rdy), 32'd0);
        rst_n = 1'b1;
        idle(2);

        for (int i = 0; i < 6; i++) begin
            applyStimulus(vecs[i], $sformatf("vec%0d", i));
        end

        // Partial command abandoned: tmo must fire exactly TMO cycles after the last accept.
        sendByte(8'h11, 1'b0, "tmo");
        idle(2);
        sendByte(8'h22, 1'b0, "tmo");
        pulses  = 0;
        firstAt = -1;
        for (int k = 1; k <= TMO + 20; k++) begin
            idle(1);
            if (tmo) begin
                pulses++;
                if (firstAt < 0) firstAt = k;
            end
        end
        checkOutput("tmo pulse count", 32'(pulses), 32'd1);
        checkOutput("tmo pulse cycle", 32'(firstAt), 32'(TMO));
        checkOutput("tmo cmd_rdy", 32'(cmd_rdy), 32'd0);
        applyStimulus('{8'h33, 8'h44, 8'h55, 1'b0, 1'b1, 24'h334455, 1'b1, 1'b0}, "after tmo");

        // Second byte lands in the very cycle the timer expires.
        sendByte(8'h77, 1'b0, "race");
        idle(TMO - 1);
        sendByte(8'h88, 1'b0, "race");
        pulses = 0;
        if (tmo) pulses++;
        for (int k = 0; k < 5; k++) begin
            idle(1);
            if (tmo) pulses++;
        end
        checkOutput("race no tmo", 32'(pulses), 32'd0);
        sendByte(8'h99, 1'b0, "race");
        checkAll("race done", 24'h778899, 1'b1, 1'b0, 1'b0);
        idle(2);

        // Reset mid-command with a word still pending.
        sendByte(8'hAA, 1'b0, "rst");
        idle(1);
        rst_n = 1'b0;
        #1;
        checkAll("rst async", 24'h0, 1'b0, 1'b0, 1'b0);
        idle(3);
        checkAll("rst held", 24'h0, 1'b0, 1'b0, 1'b0);
        checkOutput("rst clr_rx_rdy", 32'(clr_rx_rdy), 32'd0);
        rst_n = 1'b1;
        idle(2);
        applyStimulus('{8'h01, 8'h02, 8'h03, 1'b0, 1'b0, 24'h010203, 1'b1, 1'b0}, "after rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/uart_cmd_assembler.md
# uart_cmd_assembler

Byte-to-command assembler sitting directly downstream of the UART receiver. Consumes received bytes over the `rx_rdy`/`clr_rx_rdy` handshake and packs `CMD_BYTES` consecutive bytes, most-significant first, into one command word. Presents that word to the command processor with a held `cmd_rdy` flag. An inter-byte timeout resynchronises framing after a dropped byte.

## Interface

- `CMD_BYTES`, default 3: bytes per command; `cmd` width is `8*CMD_BYTES`.
- `TIMEOUT_CLKS`, default 65104: idle clocks allowed between bytes of one command. The default is about 2.5 byte times at 2604 clk/baud.
- `clk`  in  1  system clock, 50 MHz.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `rx_rdy`  in  1  UART byte available; held high until cleared.
- `rx_data`  in  8  received byte; stable while `rx_rdy` is high.
- `clr_rx_rdy`  out  1  one-cycle byte-accept strobe to the UART.
- `cmd`  out  `8*CMD_BYTES`  last completed command word.
- `cmd_rdy`  out  1  `cmd` valid and not yet consumed.
- `clr_cmd_rdy`  in  1  consumer acknowledge; clears `cmd_rdy`.
- `ovr`  out  1  one-cycle pulse: a completed command was dropped because `cmd_rdy` was still set.
- `tmo`  out  1  one-cycle pulse: a partial command was discarded on timeout.

## Operation

- **States.**
  - `IDLE`: byte count 0, timer stopped.
  - `COLLECT`: 1 to `CMD_BYTES-1` bytes held, timer running.
- **Accept.** `accept = rx_rdy` in `IDLE` or `COLLECT`. The block never stalls the UART.
  - `clr_rx_rdy = accept`, combinational, high for exactly the accept cycle.
  - The UART drops `rx_rdy` the following cycle, so there is no double capture.
- **Assembly.** On accept, `asm <= {asm[8*CMD_BYTES-9:0], rx_data}` and the byte count increments. The first byte received lands in `cmd[8*CMD_BYTES-1 -: 8]`.
- **Transitions.**
  - `IDLE` + accept → `COLLECT`, count = 1. If `CMD_BYTES == 1`, the word completes immediately and the state stays `IDLE`.
  - `COLLECT` + accept with count = `CMD_BYTES-1` → complete → `IDLE`, count = 0.
  - `COLLECT` + timer expiry with no accept → `IDLE`, count = 0, `asm` contents ignored, `tmo` pulses.
- **Completion.**
  - If `cmd_rdy == 0`, or `clr_cmd_rdy == 1` in the same cycle: `cmd <= {asm_shifted}` and `cmd_rdy <= 1`.
  - Otherwise: `cmd` and `cmd_rdy` are unchanged, `ovr` pulses, and the new word is lost.
- **Timer.**
  - Cleared on every accept; increments each clock in `COLLECT`.
  - Expiry is count == `TIMEOUT_CLKS-1`. Width is `$clog2(TIMEOUT_CLKS)`; the timer never wraps.
- **Consumer clear.** `clr_cmd_rdy` clears `cmd_rdy` next cycle. `cmd` holds its value.
- **Collection during `cmd_rdy`.** Assembly of the next command proceeds while `cmd_rdy` is high, giving double buffering.

## Timing

- **Reset values.** All outputs 0: `clr_rx_rdy`, `cmd`, `cmd_rdy`, `ovr`, `tmo`. Internal: state `IDLE`, count 0, timer 0, `asm` 0.
- **Latency.** Final-byte accept in cycle t → `cmd` valid and `cmd_rdy = 1` in t+1.
- **Pulse timing.** `ovr` and `tmo` are registered and asserted in t+1 of their event.
- **Simultaneous events.**
  - Accept in the expiry cycle: accept wins, no `tmo`, timer cleared.
  - Completion with `clr_cmd_rdy`: load wins, `cmd_rdy` stays 1, no `ovr`.
  - `clr_cmd_rdy` while `cmd_rdy == 0`: no effect.
- **Reset mid-command.** Partial bytes are discarded. `cmd_rdy` drops immediately (asynchronous). The first byte after reset is treated as byte 0.
- **Steady state.** A full-rate UART gives one accept every 26 040 clks, well inside the timeout.

## Structure

- Package `uart_cmd_pkg`: `asm_state_t` enum {`IDLE`, `COLLECT`}, `BAUD_CLKS` = 2604, `DEF_CMD_BYTES` = 3, `DEF_TIMEOUT_CLKS` = 65104.
- One sub-module: `cmd_timeout_tmr` (inputs clear, enable; output expire), parameterised by `TIMEOUT_CLKS`.
- The remaining logic is flat: state register, byte counter, `asm` shift register, `cmd` holding register, and the `cmd_rdy`/`ovr`/`tmo` flops.

## Test plan

- **Basic assembly.** Bytes 0xA5, 0x3C, 0x0F, each `rx_rdy` held until cleared → `clr_rx_rdy` one cycle per byte; `cmd` = 0xA53C0F and `cmd_rdy` = 1 one cycle after the third accept; `clr_cmd_rdy` → `cmd_rdy` = 0 next cycle, `cmd` retained.
- **Timeout.** Bytes 0x11, 0x22, then silence for 65104 clks → `tmo` pulses once and `cmd_rdy` stays 0. Then bytes 0x33, 0x44, 0x55 → `cmd` = 0x334455.
- **Overrun.** Command 0x010203 left unacknowledged, then 0x040506 → `ovr` pulses after the sixth byte and `cmd` remains 0x010203.
- **Same-cycle acknowledge.** Repeat the overrun scenario with `clr_cmd_rdy` in the completion cycle of 0x040506 → no `ovr`, `cmd` = 0x040506, `cmd_rdy` = 1.
- **Accept versus expiry.** Second byte accepted exactly in the expiry cycle → no `tmo`; third byte completes the command.
- **Reset mid-command.** `rst_n` low after byte 0xAA, then bytes 0x01, 0x02, 0x03 → `cmd` = 0x010203 and all outputs are 0 during reset.
